cart_mux_scheduler: RTL and testbench
=====================================

# cart_mux_scheduler

Programmable sequencer for the cartridge-slot signal multiplexer. It drives the 2-bit buffer select through the enabled input groups, waits a configurable settle time after each switch, and then opens a per-group sample window. Downstream pin filters and address latches use the window strobes to capture their group. It sits between the board bus front-end and the external mux buffers, replacing a fixed round-robin.

## Interface

Parameters:
- NUM_GROUPS, 4: number of mux groups; fixed at 4 (2-bit select).
- MAX_SETTLE, 7: maximum settle-cycle count; sets the counter width.
- MAX_SAMPLE, 4: maximum sample-window length in cycles.

Ports:
- CLK, in, 1: system clock.
- RESET_n, in, 1: reset, asynchronous, active-low.
- RUN, in, 1: scanning enable.
- GROUP_EN, in, 4: per-group scan mask.
- SETTLE_CFG, in, 3: cycles after a select change with no sampling (0..MAX_SETTLE).
- SAMPLE_CFG, in, 3: sample-window length (1..MAX_SAMPLE; 0 is treated as 1; values above MAX_SAMPLE saturate).
- MUX_SEL, out, 2: buffer select to pins.
- SAMPLE_EN, out, 4: one-hot; high during the active group's sample window.
- SAMPLE_LAST, out, 4: one-hot pulse in the final sample cycle of a group.
- FRAME_DONE, out, 1: one-cycle pulse in the last sample cycle of the last enabled group.
- FRAME_CNT, out, 8: completed-frame counter; wraps 255→0.
- SNAP_REQ, in, 1: consumer requests one coherent full frame.
- SNAP_ACK, out, 1: one-cycle pulse granting the snapshot.

## Operation

Reset values:
- All outputs are 0. The FSM is in IDLE, both counters are 0 and snapshot pending is cleared.

States:
- IDLE: leave only when RUN=1 and GROUP_EN≠0.
  - On that edge, latch GROUP_EN, SETTLE_CFG and SAMPLE_CFG (frame config).
  - Load MUX_SEL with the lowest enabled group.
  - Go to SETTLE, or to SAMPLE if settle=0.
- SETTLE: down-count the settle value. SAMPLE_EN=0. At the last count, go to SAMPLE.
- SAMPLE: SAMPLE_EN[MUX_SEL]=1 for the configured sample cycles. In the final cycle:
  - SAMPLE_LAST[MUX_SEL]=1.
  - If a higher-indexed enabled group exists (frame config), load MUX_SEL with it on the next edge and go to SETTLE/SAMPLE.
  - Otherwise assert FRAME_DONE and increment FRAME_CNT at the next edge. Then:
    - if RUN=1 and live GROUP_EN≠0, relatch config and restart at the lowest enabled group;
    - else go to IDLE with MUX_SEL held.

Config and group rules:
- Config changes mid-frame have no effect until the next frame start.
- Group order is always ascending index. Disabled groups cost zero cycles.

RUN and reset behaviour:
- RUN deasserted mid-frame: the current frame completes normally, then IDLE. There is no truncation.
- Reset mid-operation: all outputs and state go immediately to their reset values.

Snapshot handshake:
- SNAP_REQ is a level. Once it is seen high, pending is armed at the next frame start (IDLE exit or wrap). A frame already in progress does not count.
- SNAP_ACK pulses together with FRAME_DONE of the armed frame, then pending clears.
- If SNAP_REQ drops before the ack, pending clears and no ack is issued.
- The requester deasserts SNAP_REQ on the cycle after SNAP_ACK. A req still high two cycles after the ack counts as a new request.

## Timing

- All outputs are registered; there is no combinational path from inputs to outputs.
- Per-group cost is settle + sample cycles. Frame length is the sum over enabled groups.
  - Defaults: settle 1, sample 2, all groups enabled → 12-cycle frame.
- Start-up: RUN rises at edge 0. MUX_SEL changes at edge 1. The first SAMPLE_EN is high after edge 1+settle.
- The MUX_SEL change and the SAMPLE_EN drop of the previous group happen on the same edge. SAMPLE_EN is never high in the cycle a select changes unless settle=0.
- Wrap with a single enabled group: MUX_SEL does not change, but the settle phase is still inserted.

## Structure

- The package cart_mux_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE);
  - NUM_GROUPS;
  - default constants DEF_SETTLE=1 and DEF_SAMPLE=2;
  - a next_group(mask, cur) function: returns the lowest set bit above cur, or a valid=0 flag.
- One sub-module, cart_mux_timer: a loadable down-counter with a terminal-count flag, reused for the settle and sample phases.

## Test plan

- **Defaults, all groups:** RUN=1, GROUP_EN=4'hF, SETTLE=1, SAMPLE=2 → MUX_SEL sequence 0,1,2,3 every 3 cycles; FRAME_DONE every 12 cycles; FRAME_CNT increments by 1 per frame.
- **Sparse mask, zero settle:** GROUP_EN=4'b0101, SETTLE=0, SAMPLE=1 → MUX_SEL alternates 0,2 each cycle; SAMPLE_EN alternates 0001/0100; frame is 2 cycles.
- **Mid-frame changes:** change SETTLE_CFG to 3 and drop RUN during group 1 → the current frame keeps settle 1, finishes at group 3, then IDLE; MUX_SEL holds 3; SAMPLE_EN=0.
- **Snapshot handshake:** raise SNAP_REQ during group 2 → no ack at that frame's end; SNAP_ACK coincides with the following FRAME_DONE; dropping SNAP_REQ early in a repeat run gives no ack.
- **Async reset mid-frame:** assert RESET_n low mid-SAMPLE → all outputs 0 immediately; after release with RUN=1, restart from group 0; FRAME_CNT wraps 255→0 on a long run.

Source files
------------

// File: rtl/cart_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cart_mux_pkg
//  Description : Shared types, constants and group-walk helpers for the
//                cartridge-slot mux scheduler.
//                  state_t          - scheduler FSM states
//                  grp_t            - {valid, idx} result of a group search
//                  NUM_GROUPS       - number of mux groups (2-bit select)
//                  DEF_SETTLE/DEF_SAMPLE - default timing settings
//                  first_group()    - lowest enabled group in a mask
//                  next_group()     - lowest enabled group above cur
//                  has_next_group() - valid flag of next_group()
//  Revision    : 1.0 - initial release
// ============================================================================
package cart_mux_pkg;

    localparam int         NUM_GROUPS = 4;
    localparam logic [2:0] DEF_SETTLE = 3'd1;
    localparam logic [2:0] DEF_SAMPLE = 3'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } grp_t;

    // Lowest set bit of mask; valid=0 when the mask is empty.
    function automatic grp_t first_group(input logic [NUM_GROUPS-1:0] mask);
        grp_t r;
        r = '0;
        for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.valid = 1'b1;
                r.idx   = 2'(i);
            end
        end
        return r;
    endfunction

    // Lowest set bit of mask strictly above cur; valid=0 when none exists.
    function automatic grp_t next_group(input logic [NUM_GROUPS-1:0] mask,
                                        input logic [1:0]            cur);
        grp_t r;
        r = '0;
        for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                r.valid = 1'b1;
                r.idx   = 2'(i);
            end
        end
        return r;
    endfunction

    function automatic logic has_next_group(input logic [NUM_GROUPS-1:0] mask,
                                            input logic [1:0]            cur);
        grp_t r;
        r = next_group(mask, cur);
        return r.valid;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cart_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : cart_mux_if
//  Description : Control/status bundle between the bus front-end (master)
//                and the mux scheduler (slave).
//                  RUN, GROUP_EN, SETTLE_CFG, SAMPLE_CFG, SNAP_REQ : to slave
//                  MUX_SEL, SAMPLE_EN, SAMPLE_LAST, FRAME_DONE,
//                  FRAME_CNT, SNAP_ACK                            : to master
//  Revision    : 1.0 - initial release
// ============================================================================
interface cart_mux_if;
    import cart_mux_pkg::*;

    logic                  RUN;
    logic [NUM_GROUPS-1:0] GROUP_EN;
    logic [2:0]            SETTLE_CFG;
    logic [2:0]            SAMPLE_CFG;
    logic                  SNAP_REQ;

    logic [1:0]            MUX_SEL;
    logic [NUM_GROUPS-1:0] SAMPLE_EN;
    logic [NUM_GROUPS-1:0] SAMPLE_LAST;
    logic                  FRAME_DONE;
    logic [7:0]            FRAME_CNT;
    logic                  SNAP_ACK;

    modport master (
        output RUN, GROUP_EN, SETTLE_CFG, SAMPLE_CFG, SNAP_REQ,
        input  MUX_SEL, SAMPLE_EN, SAMPLE_LAST, FRAME_DONE, FRAME_CNT, SNAP_ACK
    );

    modport slave (
        input  RUN, GROUP_EN, SETTLE_CFG, SAMPLE_CFG, SNAP_REQ,
        output MUX_SEL, SAMPLE_EN, SAMPLE_LAST, FRAME_DONE, FRAME_CNT, SNAP_ACK
    );

endinterface
`default_nettype wire

// File: rtl/cart_mux_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cart_mux_timer
//  Description : Loadable down-counter with terminal-count flag. Shared by
//                the settle and sample phases: loading N gives N+1 cycles
//                until o_tc is seen.
//                  CLK, RESET_n : clock, async active-low reset
//                  i_load       : load i_load_val this edge
//                  i_load_val   : reload value
//                  o_count      : current count
//                  o_tc         : count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module cart_mux_timer #(
    parameter int WIDTH = 3
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);
    import cart_mux_pkg::*;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/cart_mux_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : cart_mux_scheduler
//  Description : Programmable sequencer for the cartridge-slot signal mux.
//                Walks the enabled groups in ascending order, holds a settle
//                gap after every select change and then opens a per-group
//                sample window. Frame config is latched at frame start.
//                  CLK, RESET_n : clock, async active-low reset
//                  bus (slave)  : RUN/GROUP_EN/SETTLE_CFG/SAMPLE_CFG/SNAP_REQ
//                                 in; MUX_SEL/SAMPLE_EN/SAMPLE_LAST/
//                                 FRAME_DONE/FRAME_CNT/SNAP_ACK out
//  Revision    : 1.0 - initial release
// ============================================================================
module cart_mux_scheduler #(
    parameter int NUM_GROUPS = 4,
    parameter int MAX_SETTLE = 7,
    parameter int MAX_SAMPLE = 4
) (
    input  logic       CLK,
    input  logic       RESET_n,
    cart_mux_if.slave  bus
);
    import cart_mux_pkg::*;

    localparam int CNT_W = $clog2(MAX_SETTLE + 1);

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_sel, w_sel_nxt;
    logic [NUM_GROUPS-1:0] r_mask, w_mask_nxt;
    logic [2:0]            r_settle, w_settle_nxt;
    logic [2:0]            r_samp_len, w_samp_len_nxt;
    logic [2:0]            w_cfg_len;

    logic                  w_ld;
    logic [CNT_W-1:0]      w_ld_val;
    logic [CNT_W-1:0]      w_cnt;
    logic                  w_tc;

    logic                  w_can_start, w_start, w_enter;
    grp_t                  w_first, w_next;
    logic                  w_more_after;

    logic [NUM_GROUPS-1:0] w_en_nxt, w_last_vec_nxt;
    logic                  w_last_nxt, w_done_nxt, w_pend_eff, w_ack_nxt;

    logic [NUM_GROUPS-1:0] r_sample_en, r_sample_last;
    logic                  r_frame_done, r_snap_ack, r_pend;
    logic [7:0]            r_frame_cnt;

    cart_mux_timer #(.WIDTH(CNT_W)) u_timer (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .i_load     (w_ld),
        .i_load_val (w_ld_val),
        .o_count    (w_cnt),
        .o_tc       (w_tc)
    );

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_mask     <= '0;
            r_settle   <= '0;
            r_samp_len <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_mask     <= w_mask_nxt;
            r_settle   <= w_settle_nxt;
            r_samp_len <= w_samp_len_nxt;
        end
    end

    always_comb begin
        // Sample length: 0 means 1, anything above MAX_SAMPLE saturates.
        if (bus.SAMPLE_CFG == 3'd0) begin
            w_cfg_len = 3'd1;
        end else if (int'(bus.SAMPLE_CFG) > MAX_SAMPLE) begin
            w_cfg_len = 3'(MAX_SAMPLE);
        end else begin
            w_cfg_len = bus.SAMPLE_CFG;
        end

        w_first     = first_group(bus.GROUP_EN);
        w_next      = next_group(r_mask, r_sel);
        w_can_start = bus.RUN && w_first.valid;

        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_mask_nxt     = r_mask;
        w_settle_nxt   = r_settle;
        w_samp_len_nxt = r_samp_len;
        w_start        = 1'b0;
        w_enter        = 1'b0;
        w_ld           = 1'b0;
        w_ld_val       = '0;

        case (r_state)
            IDLE: begin
                w_start = w_can_start;
            end
            SETTLE: begin
                if (w_tc) begin
                    w_state_nxt = SAMPLE;
                    w_ld        = 1'b1;
                    w_ld_val    = CNT_W'(r_samp_len - 3'd1);
                end
            end
            SAMPLE: begin
                if (w_tc) begin
                    if (w_next.valid) begin
                        w_sel_nxt = w_next.idx;
                        w_enter   = 1'b1;
                    end else if (w_can_start) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Frame start relatches the live config before the first group entry.
        if (w_start) begin
            w_enter        = 1'b1;
            w_sel_nxt      = w_first.idx;
            w_mask_nxt     = bus.GROUP_EN;
            w_settle_nxt   = bus.SETTLE_CFG;
            w_samp_len_nxt = w_cfg_len;
        end

        // Entering a group: settle gap first unless it is zero.
        if (w_enter) begin
            w_ld = 1'b1;
            if (w_settle_nxt != 3'd0) begin
                w_state_nxt = SETTLE;
                w_ld_val    = CNT_W'(w_settle_nxt - 3'd1);
            end else begin
                w_state_nxt = SAMPLE;
                w_ld_val    = CNT_W'(w_samp_len_nxt - 3'd1);
            end
        end

        // Output strobes are precomputed from the next state so they can be
        // registered and still line up with the cycle they describe.
        w_more_after = has_next_group(w_mask_nxt, w_sel_nxt);
        w_last_nxt   = (w_state_nxt == SAMPLE) &&
                       (w_ld ? (w_ld_val == '0) : (w_cnt == CNT_W'(1)));
        w_en_nxt       = '0;
        w_last_vec_nxt = '0;
        if (w_state_nxt == SAMPLE) begin
            w_en_nxt[w_sel_nxt] = 1'b1;
        end
        if (w_last_nxt) begin
            w_last_vec_nxt[w_sel_nxt] = 1'b1;
        end
        w_done_nxt = w_last_nxt && !w_more_after;

        // Snapshot arms only at a frame start; the edge that closes the ack
        // cycle is ignored so the requester's lingering level is not reused.
        w_pend_eff = (w_start && !r_snap_ack) ? bus.SNAP_REQ
                                              : (r_pend && bus.SNAP_REQ);
        w_ack_nxt  = w_done_nxt && w_pend_eff;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_sample_en   <= '0;
            r_sample_last <= '0;
            r_frame_done  <= 1'b0;
            r_snap_ack    <= 1'b0;
            r_pend        <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_sample_en   <= w_en_nxt;
            r_sample_last <= w_last_vec_nxt;
            r_frame_done  <= w_done_nxt;
            r_snap_ack    <= w_ack_nxt;
            r_pend        <= w_pend_eff && !w_ack_nxt;
            r_frame_cnt   <= r_frame_cnt + {7'd0, r_frame_done};
        end
    end

    assign bus.MUX_SEL     = r_sel;
    assign bus.SAMPLE_EN   = r_sample_en;
    assign bus.SAMPLE_LAST = r_sample_last;
    assign bus.FRAME_DONE  = r_frame_done;
    assign bus.FRAME_CNT   = r_frame_cnt;
    assign bus.SNAP_ACK    = r_snap_ack;

endmodule
`default_nettype wire

// File: tb/tb_cart_mux_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cart_mux_scheduler
//  Description : Self-checking bench for cart_mux_scheduler. A frame-level
//                reference model expands each frame into a queue of expected
//                per-cycle outputs from the config latched at frame start.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cart_mux_scheduler;
    import cart_mux_pkg::*;

    logic CLK = 1'b0;
    logic RESET_n;

    always #5 CLK = ~CLK;

    cart_mux_if bus();

    cart_mux_scheduler #(
        .NUM_GROUPS (4),
        .MAX_SETTLE (7),
        .MAX_SAMPLE (4)
    ) dut (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] en;
        logic [3:0] last;
        logic       done;
        logic       ack;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    bit         in_frame;
    bit         armed;
    logic [7:0] m_cnt;

    int  n_checks = 0;
    int  n_errors = 0;
    int  ack_seen = 0;
    bit  drop_req_next = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur      = '0;
        in_frame = 1'b0;
        armed    = 1'b0;
        m_cnt    = '0;
    endtask

    // One frame = every enabled group in ascending order, each costing
    // settle idle-select cycles followed by the sample window.
    task automatic build_frame(input logic [3:0] mask, input int settle, input int cfg);
        int   len;
        int   last_g;
        exp_t e;
        len    = (cfg == 0) ? 1 : ((cfg > 4) ? 4 : cfg);
        last_g = -1;
        for (int g = 0; g < 4; g++) if (mask[g]) last_g = g;
        for (int g = 0; g < 4; g++) begin
            if (mask[g]) begin
                for (int s = 0; s < settle; s++) begin
                    e = '0;
                    e.sel = 2'(g);
                    q.push_back(e);
                end
                for (int k = 0; k < len; k++) begin
                    e      = '0;
                    e.sel  = 2'(g);
                    e.en   = 4'b0001 << g;
                    e.last = (k == len - 1) ? e.en : 4'b0000;
                    e.done = (g == last_g) && (k == len - 1);
                    q.push_back(e);
                end
            end
        end
    endtask

    // Advance the model across one rising edge using the inputs seen there.
    task automatic model_step();
        bit   prev_ack;
        bit   start;
        exp_t e;
        prev_ack = cur.ack;
        start    = 1'b0;
        if (in_frame && cur.done) m_cnt = m_cnt + 8'd1;
        if (!in_frame || q.size() == 0) begin
            if (bus.RUN && bus.GROUP_EN != 4'b0000) start = 1'b1;
        end
        if (start) begin
            build_frame(bus.GROUP_EN, int'(bus.SETTLE_CFG), int'(bus.SAMPLE_CFG));
            armed = bus.SNAP_REQ && !prev_ack;
        end else begin
            armed = armed && bus.SNAP_REQ;
        end
        if (q.size() > 0) begin
            cur      = q.pop_front();
            in_frame = 1'b1;
        end else begin
            in_frame = 1'b0;
            e        = '0;
            e.sel    = cur.sel;
            cur      = e;
        end
        cur.ack = cur.done && armed;
        if (cur.ack) armed = 1'b0;
    endtask

    task automatic compare_outputs();
        check_val("MUX_SEL",     32'(bus.MUX_SEL),     32'(cur.sel));
        check_val("SAMPLE_EN",   32'(bus.SAMPLE_EN),   32'(cur.en));
        check_val("SAMPLE_LAST", 32'(bus.SAMPLE_LAST), 32'(cur.last));
        check_val("FRAME_DONE",  32'(bus.FRAME_DONE),  32'(cur.done));
        check_val("FRAME_CNT",   32'(bus.FRAME_CNT),   32'(m_cnt));
        check_val("SNAP_ACK",    32'(bus.SNAP_ACK),    32'(cur.ack));
        if (bus.SNAP_ACK === 1'b1) ack_seen++;
    endtask

    // Requester behaviour: drop SNAP_REQ in the cycle after the ack.
    task automatic snap_protocol();
        if (drop_req_next) begin
            bus.SNAP_REQ  = 1'b0;
            drop_req_next = 1'b0;
        end
        if (cur.ack) drop_req_next = 1'b1;
    endtask

    task automatic randomize_inputs();
        if ($urandom_range(39) == 0) bus.RUN = ~bus.RUN;
        if ($urandom_range(19) == 0) bus.GROUP_EN   = 4'($urandom_range(15));
        if ($urandom_range(15) == 0) bus.SETTLE_CFG = 3'($urandom_range(7));
        if ($urandom_range(15) == 0) bus.SAMPLE_CFG = 3'($urandom_range(7));
        if (!drop_req_next) begin
            if (!bus.SNAP_REQ && $urandom_range(29) == 0)     bus.SNAP_REQ = 1'b1;
            else if (bus.SNAP_REQ && $urandom_range(59) == 0) bus.SNAP_REQ = 1'b0;
        end
    endtask

    task automatic run_cycles(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            model_step();
            @(negedge CLK);
            compare_outputs();
            snap_protocol();
            if (rnd) randomize_inputs();
        end
    endtask

    task automatic run_until_sel(input logic [1:0] target, input int bound);
        bit found;
        found = 1'b0;
        for (int k = 0; k < bound && !found; k++) begin
            run_cycles(1, 1'b0);
            if (in_frame && cur.sel == target) found = 1'b1;
        end
        check_val("wait_sel", 32'(found), 32'd1);
    endtask

    task automatic set_cfg(input logic run, input logic [3:0] en,
                           input logic [2:0] settle, input logic [2:0] sample);
        bus.RUN        = run;
        bus.GROUP_EN   = en;
        bus.SETTLE_CFG = settle;
        bus.SAMPLE_CFG = sample;
    endtask

    initial begin
        RESET_n      = 1'b0;
        bus.SNAP_REQ = 1'b0;
        set_cfg(1'b0, 4'h0, 3'd0, 3'd0);
        model_reset();

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        compare_outputs();
        RESET_n = 1'b1;

        // Defaults, all groups enabled: 12-cycle frames
        set_cfg(1'b1, 4'hF, DEF_SETTLE, DEF_SAMPLE);
        run_cycles(40, 1'b0);

        // Sparse mask, zero settle, single-cycle windows
        set_cfg(1'b1, 4'b0101, 3'd0, 3'd1);
        run_cycles(20, 1'b0);

        // Let the last frame finish into IDLE
        bus.RUN = 1'b0;
        run_cycles(15, 1'b0);

        // Mid-frame config change and RUN drop: frame completes, then IDLE
        set_cfg(1'b1, 4'hF, DEF_SETTLE, DEF_SAMPLE);
        run_until_sel(2'd1, 40);
        bus.SETTLE_CFG = 3'd3;
        bus.RUN        = 1'b0;
        run_cycles(15, 1'b0);
        check_val("idle_mux_sel",   32'(bus.MUX_SEL),   32'd3);
        check_val("idle_sample_en", 32'(bus.SAMPLE_EN), 32'd0);

        // Snapshot raised mid-frame: ack only at the following frame's end
        set_cfg(1'b1, 4'hF, DEF_SETTLE, DEF_SAMPLE);
        run_until_sel(2'd2, 40);
        ack_seen     = 0;
        bus.SNAP_REQ = 1'b1;
        run_cycles(30, 1'b0);
        check_val("snap_ack_count", 32'(ack_seen), 32'd1);

        // Snapshot dropped before the armed frame ends: no ack
        run_until_sel(2'd2, 40);
        ack_seen     = 0;
        bus.SNAP_REQ = 1'b1;
        run_until_sel(2'd1, 40);
        bus.SNAP_REQ = 1'b0;
        run_cycles(20, 1'b0);
        check_val("snap_drop_acks", 32'(ack_seen), 32'd0);

        // Asynchronous reset in the middle of a sample window
        run_until_sel(2'd1, 40);
        run_cycles(1, 1'b0);
        check_val("pre_reset_en", 32'(bus.SAMPLE_EN), 32'b0010);
        #2 RESET_n = 1'b0;
        #1;
        check_val("rst_mux_sel",     32'(bus.MUX_SEL),     32'd0);
        check_val("rst_sample_en",   32'(bus.SAMPLE_EN),   32'd0);
        check_val("rst_sample_last", 32'(bus.SAMPLE_LAST), 32'd0);
        check_val("rst_frame_done",  32'(bus.FRAME_DONE),  32'd0);
        check_val("rst_frame_cnt",   32'(bus.FRAME_CNT),   32'd0);
        check_val("rst_snap_ack",    32'(bus.SNAP_ACK),    32'd0);
        model_reset();
        drop_req_next = 1'b0;
        bus.SNAP_REQ  = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        compare_outputs();
        RESET_n = 1'b1;
        run_cycles(14, 1'b0);

        // Randomized config, RUN and snapshot traffic
        run_cycles(3000, 1'b1);

        // One-cycle frames long enough to wrap FRAME_CNT
        drop_req_next = 1'b0;
        bus.SNAP_REQ  = 1'b0;
        set_cfg(1'b1, 4'b0001, 3'd0, 3'd1);
        run_cycles(340, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
